shift_sub_divider: RTL and testbench



---
 rtl/shift_sub_divider_pkg.sv | 39 +++
 rtl/shift_sub_divider_stage.sv | 52 +++++
 rtl/shift_sub_divider.sv | 61 ++++++
 tb/tb_shift_sub_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared types and the restoring-division step for shift_sub_divider.
// DIV_W: default operand width; the pipeline slot is sized from it.
// slot_t: one pipeline slot (valid, overflow, partial remainder, quotient,
//         remaining dividend bits, divisor).
// restoring_step: one compare/subtract step of restoring division.
package shift_sub_divider_pkg;

    localparam int unsigned DIV_W = 8;

    typedef struct packed {
        logic             valid;
        logic             overflow;
        logic [DIV_W-1:0] rem;
        logic [DIV_W-1:0] quo;
        logic [DIV_W-1:0] low;
        logic [DIV_W-1:0] divisor;
    } slot_t;

    typedef struct packed {
        logic [DIV_W-1:0] rem;
        logic             qbit;
    } step_t;

    // t is {partial remainder, next dividend bit}. Because the incoming
    // remainder is always below the divisor, the result fits in DIV_W bits.
    function automatic step_t restoring_step(input logic [DIV_W:0]   t,
                                             input logic [DIV_W-1:0] divisor);
        step_t res;
        if (t >= {1'b0, divisor}) begin
            res.rem  = DIV_W'(t - {1'b0, divisor});
            res.qbit = 1'b1;
        end else begin
            res.rem  = DIV_W'(t);
            res.qbit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_sub_divider_stage.sv
// One registered restoring-division stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   prev       : slot from the previous stage (or the input slot for stage 0)
//   next       : registered slot after one shift/subtract step
// FIRST=1 marks stage 0, which also decides overflow for the slot.
module shift_sub_divider_stage
    import shift_sub_divider_pkg::*;
#(
    parameter bit FIRST = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  slot_t prev,
    output slot_t next
);

    slot_t nxt;
    step_t step;
    logic  ovf;

    always_comb begin
        // Stage 0 sees the dividend's upper half as its remainder; if that is
        // already >= divisor the quotient cannot fit (covers divisor == 0).
        ovf  = FIRST ? (prev.rem >= prev.divisor) : prev.overflow;
        step = restoring_step({prev.rem, prev.low[DIV_W-1]}, prev.divisor);

        nxt          = '0;
        nxt.valid    = prev.valid;
        nxt.overflow = ovf;
        nxt.divisor  = prev.divisor;
        nxt.low      = prev.low << 1;
        if (ovf) begin
            // Saturated result is carried through every stage so the final
            // register already holds the value to present.
            nxt.rem = '0;
            nxt.quo = '1;
        end else begin
            nxt.rem = step.rem;
            nxt.quo = (prev.quo << 1) | {{(DIV_W-1){1'b0}}, step.qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next <= '0;
        end else begin
            next <= nxt;
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Fully pipelined restoring divider: 2W-bit dividend / W-bit divisor,
// one operation per cycle, fixed latency of W register stages.
// Ports:
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   i_operands_valid      : operands present this cycle (always accepted)
//   i_dividend, i_divisor : unsigned operands
//   o_result_valid        : result fields valid
//   o_quotient/o_remainder: unsigned results (all-ones / zero on overflow)
//   o_overflow            : quotient does not fit, including divide by zero
// The slot width comes from the package; OPERAND_WIDTH must match DIV_W.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = DIV_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_operands_valid,
    input  logic [2*OPERAND_WIDTH-1:0] i_dividend,
    input  logic [OPERAND_WIDTH-1:0]   i_divisor,
    output logic                       o_result_valid,
    output logic [OPERAND_WIDTH-1:0]   o_quotient,
    output logic [OPERAND_WIDTH-1:0]   o_remainder,
    output logic                       o_overflow
);

    slot_t head;
    slot_t pipe [DIV_W];

    always_comb begin
        head          = '0;
        head.valid    = i_operands_valid;
        head.rem      = i_dividend[2*DIV_W-1:DIV_W];
        head.low      = i_dividend[DIV_W-1:0];
        head.divisor  = i_divisor;
    end

    for (genvar k = 0; k < DIV_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_sub_divider_stage #(.FIRST(1'b1)) u_stage (
                .clk   (i_clk),
                .rst_n (i_reset_n),
                .prev  (head),
                .next  (pipe[k])
            );
        end else begin : g_rest
            shift_sub_divider_stage #(.FIRST(1'b0)) u_stage (
                .clk   (i_clk),
                .rst_n (i_reset_n),
                .prev  (pipe[k-1]),
                .next  (pipe[k])
            );
        end
    end

    assign o_result_valid = pipe[DIV_W-1].valid;
    assign o_quotient     = pipe[DIV_W-1].quo;
    assign o_remainder    = pipe[DIV_W-1].rem;
    assign o_overflow     = pipe[DIV_W-1].overflow;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider (OPERAND_WIDTH = 8).
module tb_shift_sub_divider;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [15:0]   dividend;
    logic [7:0]    divisor;
    logic          o_valid;
    logic [7:0]    o_q;
    logic [7:0]    o_r;
    logic          o_ovf;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic [7:0] r;
        logic       o;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    shift_sub_divider #(.OPERAND_WIDTH(W)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_operands_valid (valid),
        .i_dividend       (dividend),
        .i_divisor        (divisor),
        .o_result_valid   (o_valid),
        .o_quotient       (o_q),
        .o_remainder      (o_r),
        .o_overflow       (o_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({o_valid, o_q, o_r, o_ovf} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got v=%b q=%0d r=%0d o=%b need all 0",
                         cyc, o_valid, o_q, o_r, o_ovf);
            end
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_result cyc=%0d got none need q=%0d r=%0d due %0d",
                         cyc, sb[0].q, sb[0].r, sb[0].due);
                void'(sb.pop_front());
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result cyc=%0d got q=%0d r=%0d o=%b need no valid",
                             cyc, o_q, o_r, o_ovf);
                end else begin
                    e = sb.pop_front();
                    if (e.due != cyc || o_q !== e.q || o_r !== e.r || o_ovf !== e.o) begin
                        errors++;
                        $display("FAIL result cyc=%0d got q=%0d r=%0d o=%b need q=%0d r=%0d o=%b at cyc %0d",
                                 cyc, o_q, o_r, o_ovf, e.q, e.r, e.o, e.due);
                    end
                end
            end else if (o_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL valid_x cyc=%0d got %b need 0/1", cyc, o_valid);
            end
        end
    end

    task automatic issue(input logic v, input logic [15:0] dd, input logic [7:0] ds,
                         input logic [7:0] q, input logic [7:0] r, input logic o);
        exp_t x;
        @(posedge clk);
        #1;
        valid    = v;
        dividend = dd;
        divisor  = ds;
        if (v) begin
            x.due = cyc + W;
            x.q   = q;
            x.r   = r;
            x.o   = o;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 16'($urandom), 8'($urandom), 8'd0, 8'd0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset held with inputs toggling; monitor checks outputs stay 0.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            valid    = 1'($urandom);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;

        // Back-to-back stream.
        issue(1'b1, 16'd4140,  8'd230, 8'd18,  8'd0, 1'b0);
        issue(1'b1, 16'd11704, 8'd154, 8'd76,  8'd0, 1'b0);
        issue(1'b1, 16'd100,   8'd7,   8'd14,  8'd2, 1'b0);
        issue(1'b1, 16'd65025, 8'd255, 8'd255, 8'd0, 1'b0);

        // Valid, valid, bubble, valid.
        issue(1'b1, 16'd4140,  8'd230, 8'd18,  8'd0, 1'b0);
        issue(1'b1, 16'd100,   8'd7,   8'd14,  8'd2, 1'b0);
        issue(1'b0, 16'd2200,  8'd11,  8'd200, 8'd0, 1'b0);
        issue(1'b1, 16'd754,   8'd58,  8'd13,  8'd0, 1'b0);

        // Overflow boundaries.
        issue(1'b1, 16'd2559,  8'd10,  8'd255, 8'd9, 1'b0);
        issue(1'b1, 16'd2560,  8'd10,  8'd255, 8'd0, 1'b1);
        issue(1'b1, 16'd65535, 8'd0,   8'd255, 8'd0, 1'b1);
        issue(1'b1, 16'd0,     8'd0,   8'd255, 8'd0, 1'b1);
        idle(12);

        // Reset pulse with three operations in flight: they must vanish.
        issue(1'b1, 16'd4140,  8'd230, 8'd18,  8'd0, 1'b0);
        issue(1'b1, 16'd11704, 8'd154, 8'd76,  8'd0, 1'b0);
        issue(1'b1, 16'd100,   8'd7,   8'd14,  8'd2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({o_valid, o_q, o_r, o_ovf} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b q=%0d r=%0d o=%b need all 0",
                     o_valid, o_q, o_r, o_ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b1, 16'd754, 8'd58, 8'd13, 8'd0, 1'b0);
        idle(12);

        // Round trip: product of two nonzero operands divided by one operand.
        for (int i = 0; i < 500; i++) begin
            int a, b;
            a = int'($urandom_range(1, 255));
            b = int'($urandom_range(1, 255));
            issue(1'b1, 16'(a * b), 8'(b), 8'(a), 8'd0, 1'b0);
        end

        // Bounded drain.
        for (int i = 0; i < 3 * W && sb.size() > 0; i++) idle(1);
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending need 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
